// File: rtl/fu_pkg.sv
// Shared definitions for the func_unit sequencer: function-select codes, flag
// layout inside res_flags, result-buffer entry format and sequencer states.
package fu_pkg;

   localparam int DATA_W  = 32;
   localparam int FS_W    = 4;
   localparam int SH_W    = 5;
   localparam int FLAG_W  = 4;
   localparam int ENTRY_W = DATA_W + FLAG_W + FS_W + 1;

   // Bit positions inside res_flags, ordered {V,C,N,Z}
   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [FS_W-1:0] {
      FS_MOVA    = 4'b0000,
      FS_INC     = 4'b0001,
      FS_ADD     = 4'b0010,
      FS_ADDC    = 4'b0011,
      FS_SUBB    = 4'b0100,
      FS_SUB     = 4'b0101,
      FS_DEC     = 4'b0110,
      FS_MOVA2   = 4'b0111,
      FS_AND     = 4'b1000,
      FS_OR      = 4'b1001,
      FS_XOR     = 4'b1010,
      FS_NOT     = 4'b1011,
      FS_MOVB    = 4'b1100,
      FS_LSR     = 4'b1101,
      FS_LSL     = 4'b1110,
      FS_ILLEGAL = 4'b1111
   } fs_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] f;
      logic [FLAG_W-1:0] flags;
      logic [FS_W-1:0]   fs;
      logic              err;
   } entry_t;

   function automatic logic [FLAG_W-1:0] pack_flags(input logic v, input logic c,
                                                    input logic n, input logic z);
      logic [FLAG_W-1:0] fl;
      fl         = '0;
      fl[FLAG_V] = v;
      fl[FLAG_C] = c;
      fl[FLAG_N] = n;
      fl[FLAG_Z] = z;
      return fl;
   endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// Small first-word-fall-through FIFO holding captured func_unit results; the head
// entry is visible on rd_data whenever empty is low.
module fu_result_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wr_data,
   output logic [WIDTH-1:0]             rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty;
   // A push into a full buffer is legal when the head leaves on the same edge
   assign do_push = push && ((count_reg != FULL_CNT) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (do_push && !do_pop)
            count_reg <= count_reg + CNT_W'(1);
         else if (do_pop && !do_push)
            count_reg <= count_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr_reg] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;

endmodule

// File: rtl/fu_sequencer.sv
// Operation sequencer for a combinational func_unit: registers operands on accept,
// captures the result one edge later and queues it toward the result channel.
module fu_sequencer
   import fu_pkg::*;
#(
   parameter int RES_DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [3:0]  op_fs,
   input  logic [4:0]  op_sh,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [3:0]  fu_fs,
   output logic [4:0]  fu_sh,
   output logic [31:0] fu_a,
   output logic [31:0] fu_b,
   input  logic [31:0] fu_f,
   input  logic        fu_v,
   input  logic        fu_c,
   input  logic        fu_n,
   input  logic        fu_z,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_f,
   output logic [3:0]  res_flags,
   output logic [3:0]  res_fs,
   output logic        res_err,
   input  logic        flush,
   output logic [15:0] done_cnt
);
   localparam int CNT_W  = $clog2(RES_DEPTH + 1);
   localparam int LOAD_W = CNT_W + 1;
   localparam logic [LOAD_W-1:0] LOAD_MAX  = LOAD_W'(RES_DEPTH - 1);
   localparam logic [LOAD_W-1:0] LOAD_FULL = LOAD_W'(RES_DEPTH);

   state_e              state_reg;
   state_e              state_next;
   logic                rst_done_reg;
   logic                inflight_reg;
   logic                infl_err_reg;
   logic [FS_W-1:0]     infl_fs_reg;
   logic [FS_W-1:0]     fu_fs_reg;
   logic [SH_W-1:0]     fu_sh_reg;
   logic [DATA_W-1:0]   fu_a_reg;
   logic [DATA_W-1:0]   fu_b_reg;
   logic [15:0]         done_cnt_reg;
   logic [CNT_W-1:0]    occupancy;
   logic                fifo_empty;
   logic [ENTRY_W-1:0]  rd_data;
   entry_t              head;
   entry_t              wr_entry;
   logic                accept;
   logic                push;
   logic                pop;
   logic                illegal_op;
   logic [LOAD_W-1:0]   load;
   logic [LOAD_W-1:0]   occ_next;
   logic [LOAD_W-1:0]   load_next;
   logic                full_next;
   logic                empty_next;

   // Every accepted op reserves a buffer slot, so a capture can never be refused
   assign load       = {1'b0, occupancy} + LOAD_W'(inflight_reg);
   assign op_ready   = rst_done_reg && !flush && (load <= LOAD_MAX);
   assign accept     = op_valid && op_ready;
   assign illegal_op = (op_fs == FS_ILLEGAL);
   assign push       = inflight_reg && !flush;
   assign res_valid  = !fifo_empty;
   assign pop        = res_valid && res_ready && !flush;
   assign head       = entry_t'(rd_data);

   always_comb begin
      wr_entry     = '0;
      wr_entry.fs  = infl_fs_reg;
      wr_entry.err = infl_err_reg;
      if (!infl_err_reg) begin
         wr_entry.f     = fu_f;
         wr_entry.flags = pack_flags(fu_v, fu_c, fu_n, fu_z);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_done_reg <= 1'b0;
         inflight_reg <= 1'b0;
         infl_err_reg <= 1'b0;
         infl_fs_reg  <= '0;
         fu_fs_reg    <= '0;
         fu_sh_reg    <= '0;
         fu_a_reg     <= '0;
         fu_b_reg     <= '0;
         done_cnt_reg <= '0;
      end else begin
         rst_done_reg <= 1'b1;
         inflight_reg <= accept;
         if (accept) begin
            infl_fs_reg  <= op_fs;
            infl_err_reg <= illegal_op;
            // Illegal ops leave the func_unit drive untouched
            if (!illegal_op) begin
               fu_fs_reg <= op_fs;
               fu_sh_reg <= op_sh;
               fu_a_reg  <= op_a;
               fu_b_reg  <= op_b;
            end
         end
         if (pop) done_cnt_reg <= done_cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      occ_next   = {1'b0, occupancy} + LOAD_W'(push) - LOAD_W'(pop);
      load_next  = occ_next + LOAD_W'(accept);
      full_next  = (load_next >= LOAD_FULL);
      empty_next = (load_next == '0);
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (accept) state_next = full_next ? ST_STALL : ST_RUN;
         end
         ST_RUN: begin
            if (full_next)       state_next = ST_STALL;
            else if (empty_next) state_next = ST_IDLE;
         end
         ST_STALL: begin
            if (pop) state_next = empty_next ? ST_IDLE : ST_RUN;
         end
         default: state_next = ST_IDLE;
      endcase
      if (flush) state_next = ST_IDLE;
   end

   fu_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_entry),
      .rd_data (rd_data),
      .count   (occupancy),
      .empty   (fifo_empty)
   );

   // Result fields read as zero whenever the buffer is empty, including in reset
   always_comb begin
      res_f     = '0;
      res_flags = '0;
      res_fs    = '0;
      res_err   = 1'b0;
      if (res_valid) begin
         res_f     = head.f;
         res_flags = head.flags;
         res_fs    = head.fs;
         res_err   = head.err;
      end
   end

   assign fu_fs    = fu_fs_reg;
   assign fu_sh    = fu_sh_reg;
   assign fu_a     = fu_a_reg;
   assign fu_b     = fu_b_reg;
   assign done_cnt = done_cnt_reg;

endmodule

// File: tb/tb_fu_sequencer.sv
// Scoreboard bench for fu_sequencer with a behavioural func_unit attached to fu_*.
module tb_fu_sequencer;
   import fu_pkg::*;

   localparam int RES_DEPTH = 3;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_fs;
   logic [4:0]  op_sh;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  fu_fs;
   logic [4:0]  fu_sh;
   logic [31:0] fu_a;
   logic [31:0] fu_b;
   logic [31:0] fu_f;
   logic        fu_v;
   logic        fu_c;
   logic        fu_n;
   logic        fu_z;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_f;
   logic [3:0]  res_flags;
   logic [3:0]  res_fs;
   logic        res_err;
   logic        flush;
   logic [15:0] done_cnt;

   fu_sequencer #(.RES_DEPTH(RES_DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_fs     (op_fs),
      .op_sh     (op_sh),
      .op_a      (op_a),
      .op_b      (op_b),
      .fu_fs     (fu_fs),
      .fu_sh     (fu_sh),
      .fu_a      (fu_a),
      .fu_b      (fu_b),
      .fu_f      (fu_f),
      .fu_v      (fu_v),
      .fu_c      (fu_c),
      .fu_n      (fu_n),
      .fu_z      (fu_z),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_f     (res_f),
      .res_flags (res_flags),
      .res_fs    (res_fs),
      .res_err   (res_err),
      .flush     (flush),
      .done_cnt  (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   bit          verbose  = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Behavioural func_unit: returns {F, V, C, N, Z}
   function automatic logic [35:0] fu_model(input logic [3:0] fs, input logic [4:0] sh,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] f;
      logic [31:0] y;
      logic        cin;
      logic        arith;
      logic        v;
      logic        c;
      s = '0; f = '0; y = '0; cin = 1'b0; arith = 1'b0; v = 1'b0; c = 1'b0;
      case (fs)
         4'h0, 4'h7: f = a;
         4'h1: begin y = 32'h0;         cin = 1'b1; arith = 1'b1; end
         4'h2: begin y = b;                         arith = 1'b1; end
         4'h3: begin y = b;             cin = 1'b1; arith = 1'b1; end
         4'h4: begin y = ~b;                        arith = 1'b1; end
         4'h5: begin y = ~b;            cin = 1'b1; arith = 1'b1; end
         4'h6: begin y = 32'hFFFF_FFFF;             arith = 1'b1; end
         4'h8: f = a & b;
         4'h9: f = a | b;
         4'hA: f = a ^ b;
         4'hB: f = ~a;
         4'hC: f = b;
         4'hD: f = b >> sh;
         4'hE: f = b << sh;
         default: f = '0;
      endcase
      if (arith) begin
         s = {1'b0, a} + {1'b0, y} + {32'b0, cin};
         f = s[31:0];
         c = s[32];
         v = (a[31] == y[31]) && (f[31] != a[31]);
      end
      return {f, v, c, f[31], (f == 32'h0)};
   endfunction

   assign {fu_f, fu_v, fu_c, fu_n, fu_z} = fu_model(fu_fs, fu_sh, fu_a, fu_b);

   // Scoreboard: expected entries {f, flags, fs, err} queued on accept
   logic [40:0] sb[$];
   logic [31:0] popped_f[$];
   int unsigned popped_cyc[$];
   int unsigned acc_cnt  = 0;
   logic [15:0] exp_done = '0;

   always @(negedge clk) begin : monitor
      logic [40:0] e;
      logic [40:0] got;
      logic [35:0] m;
      if (!rst_n) begin
         sb.delete();
         exp_done = '0;
      end else begin
         check_eq("done_cnt", done_cnt, exp_done);
         if (flush) begin
            sb.delete();
         end else begin
            if (res_valid && res_ready) begin
               got = {res_f, res_flags, res_fs, res_err};
               check_eq("sb_nonempty", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check_eq("res_entry", got, e);
               end
               popped_f.push_back(res_f);
               popped_cyc.push_back(cyc);
               exp_done = exp_done + 16'd1;
               if (verbose)
                  $display("res  f=%08h flags=%b fs=%h err=%b", res_f, res_flags, res_fs, res_err);
            end
            if (op_valid && op_ready) begin
               acc_cnt++;
               if (op_fs == 4'hF) begin
                  e = {32'h0, 4'h0, 4'hF, 1'b1};
               end else begin
                  m = fu_model(op_fs, op_sh, op_a, op_b);
                  e = {m, op_fs, 1'b0};
               end
               sb.push_back(e);
               if (verbose)
                  $display("op   fs=%h sh=%0d a=%08h b=%08h", op_fs, op_sh, op_a, op_b);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents an op and returns 1 time unit after the edge that accepts it
   task automatic drive_op(input logic [3:0] fs, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b);
      bit got;
      op_valid = 1'b1;
      op_fs    = fs;
      op_sh    = sh;
      op_a     = a;
      op_b     = b;
      got      = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = op_ready;
         @(posedge clk);
         #1;
      end
      check_eq("op_accepted", got, 1);
   endtask

   task automatic op_idle();
      op_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while ((sb.size() != 0 || res_valid) && i < 100) begin
         step(1);
         i++;
      end
      check_eq("drain", sb.size(), 0);
   endtask

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int unsigned a0;
      int unsigned c0;
      int          f0;
      logic [15:0] d0;

      rst_n = 1'b0; op_valid = 1'b0; op_fs = '0; op_sh = '0; op_a = '0; op_b = '0;
      res_ready = 1'b0; flush = 1'b0;

      // Reset state
      step(3);
      check_eq("rst_op_ready", op_ready, 0);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_fu_a", fu_a, 0);
      check_eq("rst_done_cnt", done_cnt, 0);
      check_eq("rst_state", dut.state_reg, ST_IDLE);
      #2 rst_n = 1'b1;
      step(1);
      check_eq("op_ready_after_rst", op_ready, 1);

      // ADD overflow and two-edge latency
      res_ready = 1'b0;
      drive_op(4'h2, 5'd0, 32'h7FFF_FFFF, 32'h1);
      op_idle();
      check_eq("add_lat_edge_n", res_valid, 0);
      check_eq("add_fu_a", fu_a, 32'h7FFF_FFFF);
      check_eq("add_fu_fs", fu_fs, 4'h2);
      step(1);
      check_eq("add_lat_edge_n1", res_valid, 1);
      check_eq("add_res_f", res_f, 32'h8000_0000);
      check_eq("add_flags", res_flags, 4'b1010);
      res_ready = 1'b1;
      wait_drain();

      // Back-to-back shifts with the result side always ready
      popped_f.delete();
      popped_cyc.delete();
      drive_op(4'hE, 5'd31, 32'h0, 32'h1);
      drive_op(4'hD, 5'd4, 32'h0, 32'h8000_0000);
      op_idle();
      wait_drain();
      check_eq("shift_count", popped_f.size(), 2);
      if (popped_f.size() == 2) begin
         check_eq("lsl_f", popped_f[0], 32'h8000_0000);
         check_eq("lsr_f", popped_f[1], 32'h0800_0000);
         check_eq("shift_b2b", popped_cyc[1] - popped_cyc[0], 1);
      end

      // Back-pressure: five ops offered, three fit
      res_ready = 1'b0;
      a0 = acc_cnt;
      drive_op(4'hC, 5'd0, 32'h0, 32'h0000_1111);
      drive_op(4'h8, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      drive_op(4'h5, 5'd0, 32'h5, 32'h7);
      op_valid = 1'b1; op_fs = 4'h9; op_sh = 5'd0; op_a = 32'h00F0_0000; op_b = 32'h0000_000F;
      step(4);
      check_eq("stall_accepts", acc_cnt - a0, 3);
      check_eq("stall_op_ready", op_ready, 0);
      check_eq("stall_state", dut.state_reg, ST_STALL);
      check_eq("stall_head_f", res_f, 32'h0000_1111);
      res_ready = 1'b1;
      drive_op(4'h9, 5'd0, 32'h00F0_0000, 32'h0000_000F);
      drive_op(4'h6, 5'd0, 32'h0, 32'h0);
      op_idle();
      wait_drain();
      check_eq("stall_total", acc_cnt - a0, 5);

      // Flush with two buffered and one in flight
      res_ready = 1'b0;
      drive_op(4'h1, 5'd0, 32'h10, 32'h0);
      drive_op(4'h1, 5'd0, 32'h20, 32'h0);
      drive_op(4'h1, 5'd0, 32'h30, 32'h0);
      op_idle();
      d0 = exp_done;
      flush = 1'b1;
      #1;
      check_eq("flush_op_ready", op_ready, 0);
      check_eq("flush_pre_valid", res_valid, 1);
      step(1);
      flush = 1'b0;
      check_eq("flush_res_valid", res_valid, 0);
      check_eq("flush_state", dut.state_reg, ST_IDLE);
      check_eq("flush_done_cnt", done_cnt, d0);
      check_eq("flush_fu_a", fu_a, 32'h30);
      step(2);
      check_eq("flush_no_capture", res_valid, 0);

      // Illegal function select
      drive_op(4'hF, 5'd7, 32'h1234, 32'h5678);
      op_idle();
      check_eq("ill_fu_fs", fu_fs, 4'h1);
      check_eq("ill_fu_sh", fu_sh, 5'd0);
      check_eq("ill_fu_a", fu_a, 32'h30);
      check_eq("ill_fu_b", fu_b, 32'h0);
      step(1);
      check_eq("ill_res_valid", res_valid, 1);
      check_eq("ill_res_err", res_err, 1);
      check_eq("ill_res_f", res_f, 0);
      check_eq("ill_res_fs", res_fs, 4'hF);
      res_ready = 1'b1;
      wait_drain();

      // Reset asserted mid-operation
      res_ready = 1'b0;
      drive_op(4'h2, 5'd0, 32'h1, 32'h2);
      drive_op(4'h0, 5'd0, 32'hABCD, 32'h0);
      op_idle();
      #1 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_op_ready", op_ready, 0);
      check_eq("mid_rst_res_valid", res_valid, 0);
      check_eq("mid_rst_res_f", res_f, 0);
      check_eq("mid_rst_res_fs", res_fs, 0);
      check_eq("mid_rst_res_flags", res_flags, 0);
      check_eq("mid_rst_fu_a", fu_a, 0);
      check_eq("mid_rst_fu_fs", fu_fs, 0);
      check_eq("mid_rst_done_cnt", done_cnt, 0);
      check_eq("mid_rst_state", dut.state_reg, ST_IDLE);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step(1);
      check_eq("rel_op_ready", op_ready, 1);
      step(3);
      check_eq("rst_discard", res_valid, 0);

      // Sustained throughput and done_cnt wrap
      verbose   = 1'b0;
      res_ready = 1'b1;
      f0 = failures;
      c0 = cyc;
      for (int i = 0; i < 65535; i++) begin
         drive_op(4'h0, 5'd0, $urandom, 32'h0);
         if (failures != f0) break;
      end
      check_eq("throughput", cyc - c0, 65535);
      op_idle();
      wait_drain();
      check_eq("done_ffff", done_cnt, 16'hFFFF);
      verbose = 1'b1;
      drive_op(4'hB, 5'd0, 32'h0, 32'h0);
      op_idle();
      wait_drain();
      check_eq("done_wrap", done_cnt, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fu_sequencer.md
FU_SEQUENCER -- requirements
Module: fu_sequencer

Interface
REQ-001 SHALL have parameter RES_DEPTH, default 3, meaning result-buffer entries (minimum 3 for full throughput).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports op_valid in 1, op_ready out 1, op_fs in 4, op_sh in 5, op_a in 32, op_b in 32: the operation request channel.
REQ-005 SHALL have ports fu_fs out 4, fu_sh out 5, fu_a out 32, fu_b out 32: registered drive to the combinational func_unit.
REQ-006 SHALL have ports fu_f in 32, fu_v in 1, fu_c in 1, fu_n in 1, fu_z in 1: func_unit result and flags.
REQ-007 SHALL have ports res_valid out 1, res_ready in 1, res_f out 32, res_flags out 4 {V,C,N,Z}, res_fs out 4, res_err out 1: the result channel.
REQ-008 SHALL have port flush in 1: synchronous discard of all in-flight and buffered work.
REQ-009 SHALL have port done_cnt out 16: count of results popped.

Function
REQ-010 SHALL transfer on op_* when op_valid && op_ready at a rising edge, and on res_* when res_valid && res_ready at a rising edge.
REQ-011 SHALL drive op_ready only from registered state: op_ready = !flush && (occupancy + inflight) <= RES_DEPTH-1.
REQ-012 SHALL load fu_fs/fu_sh/fu_a/fu_b at the accepting edge N and set inflight=1; otherwise fu_* hold their last values and inflight=0.
REQ-013 SHALL capture fu_f, {fu_v,fu_c,fu_n,fu_z} and the tagged FS into the result buffer at edge N+1, giving 2-edge accept-to-res_valid latency.
REQ-014 SHALL sustain one operation per cycle when res_ready is held high.
REQ-015 SHALL treat op_fs = 4'b1111 as illegal: accepted, fu_* not updated, entry captured with res_f=0, res_flags=0, res_err=1.
REQ-016 SHALL present res_* from the buffer head in FIFO order, stable while res_valid && !res_ready.
REQ-017 SHALL allow push and pop on the same edge with occupancy unchanged, including when the buffer is full.
REQ-018 SHALL wrap buffer pointers modulo RES_DEPTH.
REQ-019 SHALL increment done_cnt by 1 per pop, wrapping from 16'hFFFF to 0.
REQ-020 SHALL, on flush high at an edge, clear occupancy and inflight, drop any capture due that edge, accept no op, perform no pop, and leave done_cnt and fu_* unchanged.
REQ-021 SHALL keep a state machine with states IDLE (empty, no inflight), RUN (inflight or 0 < occupancy < RES_DEPTH-inflight), STALL (op_ready=0).
REQ-022 SHALL transition IDLE->RUN on accept; RUN->STALL when occupancy+inflight reaches RES_DEPTH; STALL->RUN on pop; RUN->IDLE when the last entry pops with nothing inflight; any->IDLE on flush.

Reset
REQ-023 SHALL, while rst_n=0, force op_ready=0, res_valid=0, res_f=0, res_flags=0, res_fs=0, res_err=0, fu_fs=0, fu_sh=0, fu_a=0, fu_b=0, done_cnt=0, state=IDLE, occupancy=0, inflight=0.
REQ-024 SHALL discard any in-flight operation when reset asserts mid-operation and raise op_ready on the first edge after rst_n deasserts.

Structure
REQ-025 SHALL take FS encodings (0000 MOVA ... 1110 LSL, 1111 illegal), flag bit positions and the state enum from shared package fu_pkg.
REQ-026 SHALL implement the result buffer as sub-module fu_result_fifo (width 41, depth RES_DEPTH, synchronous clear).

Verification
REQ-027 SHALL cover: FS=0010, A=7FFF_FFFF, B=1 -> res_f=8000_0000, res_flags V=1 N=1 C=0 Z=0, res_valid two edges after accept.
REQ-028 SHALL cover: FS=1110, B=1, SH=31 then FS=1101, B=8000_0000, SH=4 back-to-back with res_ready=1 -> results 8000_0000 then 0800_0000 on consecutive cycles.
REQ-029 SHALL cover: res_ready=0 with 5 ops offered -> exactly 3 accepted, op_ready=0, state STALL; raise res_ready -> 3 results in order, remaining ops accepted.
REQ-030 SHALL cover: flush with 2 buffered and 1 inflight -> res_valid=0 next cycle, state IDLE, done_cnt unchanged.
REQ-031 SHALL cover: op_fs=1111 -> res_err=1, res_f=0, fu_* unchanged.
REQ-032 SHALL cover: rst_n low mid-operation -> all outputs zero immediately; done_cnt at FFFF plus one pop -> 0000.
